// File: rtl/axi_lite_hex_mem.sv
// 16x4 register file behind a minimal AXI-Lite-style slave (AR/R plus combined AW+W),
// packaged as a TinyTapeout tile; the last read value is shown on a 7-segment display.
module axi_lite_hex_mem (
  input  logic       clk,
  input  logic       rst_n,   // active-high synchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [0:0] {RIdle, RData} r_state_e;
  typedef enum logic [0:0] {WIdle, WBusy} w_state_e;

  r_state_e   r_state_q, r_state_d;
  w_state_e   w_state_q, w_state_d;
  logic [3:0] mem_q [16];
  logic [7:0] disp_q;

  logic [3:0] addr;
  logic [3:0] wdata;
  logic       arvalid, rready, awvalid, wvalid;
  logic       arready, rvalid, awready, wready;
  logic       rd_accept, wr_accept;

  assign addr    = ui_in[3:0];
  assign wdata   = ui_in[7:4];
  assign arvalid = uio_in[0];
  assign rready  = uio_in[1];
  assign awvalid = uio_in[2];
  assign wvalid  = uio_in[3];

  logic unused_ok;
  assign unused_ok = ^{ena, uio_in[7:4]};

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // State registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (arvalid) r_state_d = RData;
      RData:   if (rready)  r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase

    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (awvalid && wvalid) w_state_d = WBusy;
      WBusy:   w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Output decode
  always_comb begin
    arready = (r_state_q == RIdle);
    rvalid  = (r_state_q == RData);
    awready = (w_state_q == WIdle);
    wready  = (w_state_q == WIdle);
  end

  assign rd_accept = arready && arvalid;
  assign wr_accept = awready && awvalid && wvalid;

  // Memory and display; a same-edge read sees the pre-write value
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 4'(i);
      disp_q <= 8'h00;
    end else begin
      if (rd_accept) disp_q <= {1'b0, seg(mem_q[addr])};
      if (wr_accept) mem_q[addr] <= wdata;
    end
  end

  assign uo_out  = disp_q;
  assign uio_out = {wready, awready, rvalid, arready, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_axi_lite_hex_mem.sv
// Directed plus randomized checks of axi_lite_hex_mem against a transaction-level memory model.
module tb_axi_lite_hex_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  logic [3:0] mdl [16];
  logic [7:0] seg_tab [16];
  logic [7:0] disp_exp;

  axi_lite_hex_mem dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 4'(i);
    disp_exp = 8'h00;
  endtask

  task automatic set_ctl(input logic ar, input logic r, input logic aw, input logic w);
    uio_in = {4'h0, w, aw, r, ar};
  endtask

  // Full read handshake; rready is already high in the first data cycle
  task automatic do_read(input logic [3:0] a, input string tag);
    ui_in[3:0] = a;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    disp_exp = seg_tab[mdl[a]];
    chk({tag, ".rvalid"}, 8'(uio_out[5]), 8'd1);
    chk({tag, ".arready"}, 8'(uio_out[4]), 8'd0);
    chk({tag, ".data"}, uo_out, disp_exp);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rvalid_done"}, 8'(uio_out[5]), 8'd0);
    chk({tag, ".hold"}, uo_out, disp_exp);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d, input string tag);
    ui_in = {d, a};
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    mdl[a] = d;
    chk({tag, ".busy"}, {uio_out[7:6], 6'b0}, 8'h00);
    chk({tag, ".disp"}, uo_out, disp_exp);
    tick();
    chk({tag, ".ready"}, {uio_out[7:6], 6'b0}, 8'hC0);
  endtask

  initial begin
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    model_reset();
    tick();
    rst_n = 1'b0;
    chk("reset.uo_out", uo_out, 8'h00);
    chk("reset.uio_out", uio_out, 8'hD0);
    chk("reset.uio_oe", uio_oe, 8'hF0);

    do_read(4'd3, "rd3");
    chk("rd3.seg", uo_out, 8'h4F);
    do_write(4'd3, 4'd4, "wr3");
    do_read(4'd3, "rd3b");
    chk("rd3b.seg", uo_out, 8'h66);
    do_read(4'd4, "rd4");
    chk("rd4.seg", uo_out, 8'h66);
    do_read(4'd15, "rd15");
    chk("rd15.seg", uo_out, 8'h71);

    // Half of a write channel must never commit
    ui_in = 8'h95;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("partial_aw.ready", {uio_out[7:6], 6'b0}, 8'hC0);
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("partial_w.ready", {uio_out[7:6], 6'b0}, 8'hC0);
    do_read(4'd5, "rd5");
    chk("rd5.seg", uo_out, 8'h6D);

    // Simultaneous read and write: read returns the old value
    ui_in = 8'hA7;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    chk("simul.seg", uo_out, 8'h07);
    chk("simul.flags", uio_out, 8'h20);
    mdl[7] = 4'hA;
    disp_exp = 8'h07;
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    do_read(4'd7, "rd7");
    chk("rd7.seg", uo_out, 8'h77);

    // arvalid is ignored while data is pending
    ui_in[3:0] = 4'd1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    ui_in[3:0] = 4'd2;
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ignore_ar.seg", uo_out, 8'h06);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    disp_exp = 8'h06;

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [3:0] a, d;
      int op;
      a  = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      op = int'($urandom_range(0, 2));
      if (op == 0) do_read(a, "rnd_rd");
      else if (op == 1) do_write(a, d, "rnd_wr");
      else begin
        ui_in = {d, a};
        set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        disp_exp = seg_tab[mdl[a]];
        mdl[a] = d;
        chk("rnd_rw.seg", uo_out, disp_exp);
        chk("rnd_rw.flags", uio_out, 8'h20);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rnd_rw.idle", uio_out, 8'hD0);
      end
    end

    // Reset in the middle of a read
    ui_in[3:0] = 4'd2;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrd.rvalid", 8'(uio_out[5]), 8'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    model_reset();
    chk("midrd.uo_out", uo_out, 8'h00);
    chk("midrd.uio_out", uio_out, 8'hD0);
    do_read(4'd3, "post_rst_rd3");
    chk("post_rst_rd3.seg", uo_out, 8'h4F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_hex_mem.md
Name: axi_lite_hex_mem

Overview:
- 16-entry x 4-bit register file with a minimal AXI-Lite-style slave interface, packaged in the TinyTapeout tt_um pin format.
- Supports one read channel (AR/R) and one combined write channel (AW+W). There is no write-response channel.
- The last read data is shown on a 7-segment hex display driven from uo_out.
- Sits at top level, with pins driven by a test master or switches.

Parameters:
- None. Address width is fixed at 4 bits and data width at 4 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-high reset. The port keeps the codebase name rst_n; a value of 1 sampled at a rising edge resets the block.
- ena  in  1  TinyTapeout enable; ignored, the block is always active.
- ui_in  in  8  [3:0] address for both reads and writes; [7:4] write data.
- uio_in  in  8  [0] arvalid, [1] rready, [2] awvalid, [3] wvalid; [7:4] ignored.
- uo_out  out  8  7-segment display of last read data. [6:0] = {g,f,e,d,c,b,a}, active-high; [7] = decimal point, always 0.
- uio_out  out  8  [4] arready, [5] rvalid, [6] awready, [7] wready; [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset (rst_n=1 at an edge):
  - mem[i] <= i for i = 0..15.
  - Read FSM enters R_IDLE; write FSM enters W_IDLE.
  - Display register <= 8'h00 (blank).
  - rvalid=0, arready=1, awready=1, wready=1.
  - Reset mid-transaction aborts it: an in-flight write is dropped, and rvalid drops on the next edge.
- Read FSM:
  - R_IDLE: arready=1, rvalid=0. At an edge with arvalid=1:
    - latch raddr=ui_in[3:0];
    - load rdata=mem[raddr];
    - load the display register with seg(mem[raddr]);
    - move to R_DATA.
  - R_DATA: arready=0, rvalid=1. Data is held stable. At an edge with rready=1, return to R_IDLE. arvalid is ignored in this state.
  - Latency: rvalid and the new uo_out value appear one cycle after arvalid is sampled.
  - rready may already be high in that first R_DATA cycle; the handshake then completes at the next edge.
- Write FSM:
  - W_IDLE: awready=wready=1. At an edge with awvalid=1 and wvalid=1: mem[ui_in[3:0]] <= ui_in[7:4], then move to W_BUSY.
  - If only one of awvalid/wvalid is high, nothing happens and the FSM stays in W_IDLE.
  - W_BUSY: awready=wready=0 for exactly one cycle, then return to W_IDLE unconditionally.
  - Writes never change the display.
- Simultaneous read accept and write at the same edge: both are accepted. The read returns the pre-write memory value (read-old).
- Display holds its value until the next accepted read.
- seg() encoding, digit->value:
  - 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07
  - 8->7F, 9->6F, A->77, b->7C, C->39, d->5E, E->79, F->71
- All outputs are registered or FSM-decoded. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst_n=1 for 1 cycle, then release to 0 -> uo_out=00, arready=1, awready=wready=1, rvalid=0, uio_oe=F0, uio_out[3:0]=0.
- Read addr 3 after reset:
  - Stimulus: arvalid=1 with ui_in[3:0]=3 for 1 cycle, then rready=1 for 1 cycle.
  - Response: rvalid=1 and arready=0 on the cycle after arvalid, with uo_out=4F; rvalid returns to 0 after the rready edge; uo_out stays 4F.
- Write then read:
  - Stimulus: awvalid=wvalid=1, ui_in=8'h43 (addr 3, data 4) for 1 cycle; then read addr 3.
  - Response: awready=wready=0 for one cycle after the write; the subsequent read gives uo_out=66.
- Read addr 4 -> uo_out=66; read addr 15 -> uo_out=71.
- Partial write:
  - Stimulus: awvalid=1 with wvalid=0 for several cycles, with ui_in=8'h95.
  - Response: mem[5] unchanged, and a read of addr 5 gives 6D.
- Simultaneous read/write:
  - Stimulus: arvalid, awvalid and wvalid all 1 on the same cycle, ui_in=8'hA7.
  - Response: the read shows 07. A following read of addr 7 shows 77.
- Reset mid-read: assert rst_n=1 while rvalid=1 -> rvalid=0 and uo_out=00 after that edge.
